// File: rtl/fp_mul_sequencer.sv
// Load/compute/capture sequencer for the single-precision FP multiplier core.
// Presents captured products and flags on a valid/ready result stream.
module fp_mul_sequencer #(
  parameter int MUL_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_enableA,
  output logic             mul_enableB,
  output logic             mul_enableOut,
  output logic             mul_reset,
  input  logic [31:0]      mul_product,
  input  logic             mul_overflow,
  input  logic             mul_infinity,
  input  logic             mul_nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_product,
  output logic [2:0]       out_flags,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] cnt_ops,
  output logic [CNT_W-1:0] cnt_exc
);

  localparam int LW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(MUL_LATENCY - 1);

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    LOAD,
    WAIT,
    HOLD
  } state_t;

  state_t        state;
  logic [LW-1:0] lat;
  logic          handshake;

  // Strobes decode straight from the state register: no input-to-output path.
  assign mul_reset     = (state == FLUSH);
  assign in_ready      = (state == IDLE);
  assign mul_enableA   = (state == LOAD);
  assign mul_enableB   = (state == LOAD);
  assign mul_enableOut = (state == WAIT);
  assign out_valid     = (state == HOLD);
  assign handshake     = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FLUSH;
      lat         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_product <= '0;
      out_flags   <= '0;
    end else begin
      unique case (state)
        FLUSH: state <= IDLE;
        IDLE: begin
          if (in_valid) begin
            mul_a <= in_a;
            mul_b <= in_b;
            state <= LOAD;
          end
        end
        LOAD: begin
          lat   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (lat == LAT_LAST) begin
            out_product <= mul_product;
            out_flags   <= {mul_nan, mul_infinity, mul_overflow};
            state       <= HOLD;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= FLUSH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_ops <= '0;
      cnt_exc <= '0;
    end else if (clear_cnt) begin
      cnt_ops <= '0;
      cnt_exc <= '0;
    end else if (handshake) begin
      if (cnt_ops != '1) cnt_ops <= cnt_ops + 1'b1;
      if ((out_flags != 3'b000) && (cnt_exc != '1))
        cnt_exc <= cnt_exc + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Bench for fp_mul_sequencer: core stand-in, result scoreboard, directed tests.
// Timing is observed on falling edges; inputs change 1 time unit after rising edges.
module tb_fp_mul_sequencer;

  localparam int LAT = 2;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic          mul_enableA;
  logic          mul_enableB;
  logic          mul_enableOut;
  logic          mul_reset;
  logic [31:0]   mul_product;
  logic          mul_overflow;
  logic          mul_infinity;
  logic          mul_nan;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_product;
  logic [2:0]    out_flags;
  logic          clear_cnt;
  logic [CW-1:0] cnt_ops;
  logic [CW-1:0] cnt_exc;

  int n_cmp  = 0;
  int n_fail = 0;

  fp_mul_sequencer #(.MUL_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_enableA(mul_enableA), .mul_enableB(mul_enableB),
    .mul_enableOut(mul_enableOut), .mul_reset(mul_reset),
    .mul_product(mul_product), .mul_overflow(mul_overflow),
    .mul_infinity(mul_infinity), .mul_nan(mul_nan),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_flags(out_flags),
    .clear_cnt(clear_cnt), .cnt_ops(cnt_ops), .cnt_exc(cnt_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stand-in core result: {flags, product} for a few known pairs, a+b otherwise.
  function automatic logic [34:0] core_f(logic [31:0] a, logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000) return {3'b000, 32'h40C00000};
    if (a == 32'h7F000000 && b == 32'h7F000000) return {3'b001, 32'h7F800000};
    if (a == 32'h7FC00000 && b == 32'h3F800000) return {3'b100, 32'h7FC00000};
    return {3'b000, a + b};
  endfunction

  // Core stand-in: operand registers, then an enabled output register.
  logic [31:0] ra, rb;
  always @(posedge clk) begin
    if (mul_reset) begin
      ra <= '0;
      rb <= '0;
      {mul_nan, mul_infinity, mul_overflow, mul_product} <= '0;
    end else begin
      if (mul_enableA) ra <= mul_a;
      if (mul_enableB) rb <= mul_b;
      if (mul_enableOut)
        {mul_nan, mul_infinity, mul_overflow, mul_product} <= core_f(ra, rb);
    end
  end

  // Scoreboard: every accepted pair yields one result, in order, with counters.
  logic [34:0] exp_q[$];
  int          m_ops = 0;
  int          m_exc = 0;
  always @(negedge clk) begin
    logic [34:0] e;
    if (reset) begin
      exp_q.delete();
      m_ops = 0;
      m_exc = 0;
      chk("rst_mul_reset", mul_reset, 1);
      chk("rst_idle_outs", {in_ready, out_valid, mul_enableA, mul_enableOut}, 0);
      chk("rst_cnt", {cnt_ops, cnt_exc}, 0);
    end else begin
      chk("cnt_ops", cnt_ops, m_ops);
      chk("cnt_exc", cnt_exc, m_exc);
      if (in_valid && in_ready) exp_q.push_back(core_f(in_a, in_b));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_product", out_product, e[31:0]);
          chk("out_flags", out_flags, e[34:32]);
          if (!clear_cnt) begin
            if (m_ops < 15) m_ops++;
            if (e[34:32] != 0 && m_exc < 15) m_exc++;
          end
        end
      end
      if (clear_cnt) begin
        m_ops = 0;
        m_exc = 0;
      end
    end
  end

  task automatic send(logic [31:0] a, logic [31:0] b);
    int w;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b;
    w = 0;
    do begin @(negedge clk); w++; end while (!in_ready && w < 50);
    if (!in_ready) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [31:0] p, output logic [2:0] f);
    int w;
    w = 0;
    do begin @(negedge clk); w++; end while (!out_valid && w < 50);
    if (!out_valid) chk("out_timeout", 1, 0);
    p = out_product;
    f = out_flags;
  endtask

  // Streams n pairs with in_valid held; checks acceptance spacing.
  task automatic stream(int n, logic [31:0] base);
    int w;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = base; in_b = 0;
    for (int i = 0; i < n; i++) begin
      w = 0;
      do begin @(negedge clk); w++; end while (!in_ready && w < 50);
      if (!in_ready) chk("stream_timeout", 1, 0);
      if (i > 0) chk("stream_gap", w, LAT + 3);
      @(posedge clk); #1;
      if (i == n - 1) in_valid = 1'b0;
      else begin
        in_a = base + i + 1;
        in_b = i + 1;
      end
    end
  endtask

  logic [31:0] p;
  logic [2:0]  f;
  logic        saw_ov;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; clear_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("flush_mul_reset", mul_reset, 1);
    chk("flush_in_ready", in_ready, 0);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_mul_reset", mul_reset, 0);

    // Basic op: strobe order and latency
    out_ready = 1'b1;
    send(32'h40000000, 32'h40400000);
    @(negedge clk);
    chk("load_en", {mul_enableA, mul_enableB, mul_enableOut}, 3'b110);
    chk("load_mul_a", mul_a, 32'h40000000);
    chk("load_mul_b", mul_b, 32'h40400000);
    @(negedge clk);
    chk("wait1_en", {mul_enableA, mul_enableB, mul_enableOut, out_valid}, 4'b0010);
    @(negedge clk);
    chk("wait2_en", {mul_enableA, mul_enableB, mul_enableOut, out_valid}, 4'b0010);
    @(negedge clk);
    chk("basic_out_valid", out_valid, 1);
    chk("basic_enout", mul_enableOut, 0);
    chk("basic_product", out_product, 32'h40C00000);
    chk("basic_flags", out_flags, 3'b000);
    @(negedge clk);
    chk("basic_cnt_ops", cnt_ops, 1);
    chk("basic_done", out_valid, 0);

    // Backpressure in HOLD
    out_ready = 1'b0;
    send(32'h1, 32'h2);
    wait_out(p, f);
    chk("bp_product", p, 32'h3);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 32'h5; in_b = 32'h6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready}, 2'b10);
      chk("bp_stable", out_product, 32'h3);
      chk("bp_mul_a", mul_a, 32'h1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_load", {mul_a, mul_enableA}, {32'h5, 1'b1});
    wait_out(p, f);
    chk("bp_second_product", p, 32'hB);
    @(negedge clk);
    chk("bp_cnt_ops", cnt_ops, 3);

    // Exceptions
    send(32'h7F000000, 32'h7F000000);
    wait_out(p, f);
    chk("ovf_product", p, 32'h7F800000);
    chk("ovf_flags", f, 3'b001);
    @(negedge clk);
    chk("ovf_cnt_exc", cnt_exc, 1);
    send(32'h7FC00000, 32'h3F800000);
    wait_out(p, f);
    chk("nan_flags", f, 3'b100);
    @(negedge clk);
    chk("nan_cnt_exc", cnt_exc, 2);
    chk("nan_cnt_ops", cnt_ops, 5);

    // Reset during the first WAIT cycle
    send(32'h1, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_mul_reset", mul_reset, 1);
    chk("abort_outs", {mul_enableA, mul_enableB, mul_enableOut, out_valid, in_ready}, 0);
    chk("abort_data", {mul_a, mul_b, out_product}, 0);
    chk("abort_cnt", cnt_ops, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_flush", {mul_reset, in_ready}, 2'b10);
    @(negedge clk);
    chk("abort_idle", {mul_reset, in_ready}, 2'b01);
    saw_ov = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw_ov = 1'b1;
    end
    chk("abort_no_out_valid", saw_ov, 0);
    chk("abort_cnt_ops", cnt_ops, 0);

    // Streaming with both handshakes held high
    stream(3, 32'h1000);
    wait_out(p, f);
    @(negedge clk);
    chk("stream_cnt_ops", cnt_ops, 3);

    // Saturation
    @(posedge clk); #1 clear_cnt = 1'b1;
    @(posedge clk); #1 clear_cnt = 1'b0;
    stream(17, 32'h100);
    wait_out(p, f);
    @(negedge clk);
    chk("sat_cnt_ops", cnt_ops, 15);

    // Clear on a handshake cycle wins
    out_ready = 1'b0;
    send(32'h2, 32'h3);
    wait_out(p, f);
    @(posedge clk); #1;
    out_ready = 1'b1; clear_cnt = 1'b1;
    @(posedge clk); #1;
    clear_cnt = 1'b0;
    @(negedge clk);
    chk("clear_hs_cnt_ops", cnt_ops, 0);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
